lsu_sequencer: RTL and testbench

Multi-cycle load/store sequencer between the RV32I decode/execute stage and a handshaked data memory. It takes one decoded load or store, checks its alignment, and drives a single word-aligned memory request with byte enables and a lane-replicated write word. It holds `stall` to freeze PC and pipeline until the access finishes, then returns sign- or zero-extended load data. Its sub-word controls come from the main controller's LB/LH/LBU/LHU/SB/SH and st_en outputs.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_sequencer_if.sv | 25 ++
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/lsu_sequencer.sv | 141 ++++++++++++++
 tb/tb_lsu_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
// Holds FSM states, access sizes, byte-enable patterns and an alignment helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } lsu_size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_misaligned(lsu_size_e sz, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (sz)
            HALF:    bad = off[0];
            WORD:    bad = |off;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Handshaked data-memory bus between the sequencer and memory.
// master: sequencer drives req/we/addr/be/wdata; slave: memory drives rdata/ack.
interface lsu_sequencer_if #(
    parameter int Width = 32
);

    logic             mem_req;
    logic             mem_we;
    logic [Width-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [Width-1:0] mem_wdata;
    logic [Width-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables, replicated store data, load extension.
// In: size, is_signed, off, wdata, rdata. Out: be, st_data, ld_data.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int Width = 32
) (
    input  lsu_size_e        size,
    input  logic             is_signed,
    input  logic [1:0]       off,
    input  logic [Width-1:0] wdata,
    input  logic [Width-1:0] rdata,
    output logic [3:0]       be,
    output logic [Width-1:0] st_data,
    output logic [Width-1:0] ld_data
);

    logic [7:0]  b_lane;
    logic [15:0] h_lane;

    always_comb begin
        b_lane  = rdata[{off, 3'b000} +: 8];
        h_lane  = rdata[{off[1], 4'b0000} +: 16];
        be      = BE_WORD;
        st_data = wdata;
        ld_data = rdata;
        case (size)
            BYTE: begin
                be      = BE_BYTE << off;
                st_data = {4{wdata[7:0]}};
                ld_data = {{24{is_signed & b_lane[7]}}, b_lane};
            end
            HALF: begin
                be      = BE_HALF << {off[1], 1'b0};
                st_data = {2{wdata[15:0]}};
                ld_data = {{16{is_signed & h_lane[15]}}, h_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: one aligned word request per access, stalls pipe.
// Ports: clk, rst, lsu_valid, st_en, LB/LH/LBU/LHU/SB/SH, addr, wdata, mem bus, stall, ld_data, done, misalign, timeout.
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int Width   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu_valid,
    input  logic             st_en,
    input  logic             LB,
    input  logic             LH,
    input  logic             LBU,
    input  logic             LHU,
    input  logic             SB,
    input  logic             SH,
    input  logic [Width-1:0] addr,
    input  logic [Width-1:0] wdata,
    lsu_sequencer_if.master  mem,
    output logic             stall,
    output logic [Width-1:0] ld_data,
    output logic             done,
    output logic             misalign,
    output logic             timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e state;
    lsu_size_e  d_size, r_size, a_size;
    logic       d_signed, r_signed, a_signed;
    logic [1:0] r_off, a_off;
    logic [CW-1:0] cnt;

    logic [3:0]       a_be;
    logic [Width-1:0] a_st, a_ld;

    // Load flags are ignored on stores and store flags on loads.
    always_comb begin
        d_size   = WORD;
        d_signed = 1'b0;
        if (st_en) begin
            if (SB)      d_size = BYTE;
            else if (SH) d_size = HALF;
        end else if (LB) begin
            d_size   = BYTE;
            d_signed = 1'b1;
        end else if (LH) begin
            d_size   = HALF;
            d_signed = 1'b1;
        end else if (LBU) begin
            d_size = BYTE;
        end else if (LHU) begin
            d_size = HALF;
        end
    end

    // One lane unit: fed by the live instruction in IDLE, by the captured one later.
    always_comb begin
        a_size   = (state == IDLE) ? d_size : r_size;
        a_signed = (state == IDLE) ? d_signed : r_signed;
        a_off    = (state == IDLE) ? addr[1:0] : r_off;
    end

    lsu_lane_align #(.Width(Width)) u_align (
        .size      (a_size),
        .is_signed (a_signed),
        .off       (a_off),
        .wdata     (wdata),
        .rdata     (mem.mem_rdata),
        .be        (a_be),
        .st_data   (a_st),
        .ld_data   (a_ld)
    );

    assign stall = !rst && ((state == REQ) || (state == IDLE && lsu_valid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            r_size        <= WORD;
            r_signed      <= 1'b0;
            r_off         <= 2'b00;
            cnt           <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'b0000;
            mem.mem_wdata <= '0;
            ld_data       <= '0;
            done          <= 1'b0;
            misalign      <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_valid) begin
                        if (is_misaligned(d_size, addr[1:0])) begin
                            state    <= ERR;
                            misalign <= 1'b1;
                        end else begin
                            state         <= REQ;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= st_en;
                            mem.mem_addr  <= {addr[Width-1:2], 2'b00};
                            mem.mem_be    <= a_be;
                            mem.mem_wdata <= a_st;
                            r_size        <= d_size;
                            r_signed      <= d_signed;
                            r_off         <= addr[1:0];
                            cnt           <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        state       <= DONE;
                        mem.mem_req <= 1'b0;
                        done        <= 1'b1;
                        if (!mem.mem_we) ld_data <= a_ld;
                    end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
                        state       <= ERR;
                        mem.mem_req <= 1'b0;
                        timeout     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: directed cases then randomized accesses.
// Expected values come from an arithmetic model of sizes, lanes and timing.
module tb_lsu_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, st_en;
    logic        LB, LH, LBU, LHU, SB, SH;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, timeout;
    logic [31:0] ld_data;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_ld   = 32'h0;

    always #5 clk = ~clk;

    lsu_sequencer_if #(.Width(32)) bus ();

    lsu_sequencer #(.Width(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu_valid (lsu_valid),
        .st_en     (st_en),
        .LB        (LB),
        .LH        (LH),
        .LBU       (LBU),
        .LHU       (LHU),
        .SB        (SB),
        .SH        (SH),
        .addr      (addr),
        .wdata     (wdata),
        .mem       (bus),
        .stall     (stall),
        .ld_data   (ld_data),
        .done      (done),
        .misalign  (misalign),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fl = {LB, LH, LBU, LHU, SB, SH}
    task automatic op(input logic st, input logic [5:0] fl, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int waits, input bit hold_valid);
        int          sz, off;
        bit          sgn, mis, acked;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld;
        logic [7:0]  b;
        logic [15:0] h;

        sz  = 4;
        sgn = 0;
        if (st) begin
            if (fl[1]) sz = 1;
            else if (fl[0]) sz = 2;
        end else if (fl[5]) begin
            sz = 1; sgn = 1;
        end else if (fl[4]) begin
            sz = 2; sgn = 1;
        end else if (fl[3]) sz = 1;
        else if (fl[2]) sz = 2;

        off = int'(a[1:0]);
        mis = (sz == 2 && off % 2 == 1) || (sz == 4 && off != 0);
        if (sz == 1) begin
            ebe = 4'(1 << off);
            ewd = {24'h0, wd[7:0]} * 32'h01010101;
            b   = 8'(rd >> (8 * off));
            eld = 32'(b);
            if (sgn && b >= 8'd128) eld = eld - 32'd256;
        end else if (sz == 2) begin
            ebe = 4'(3 << ((off / 2) * 2));
            ewd = {16'h0, wd[15:0]} * 32'h00010001;
            h   = 16'(rd >> (16 * (off / 2)));
            eld = 32'(h);
            if (sgn && h >= 16'd32768) eld = eld - 32'd65536;
        end else begin
            ebe = 4'hF;
            ewd = wd;
            eld = rd;
        end

        lsu_valid = 1'b1;
        st_en     = st;
        {LB, LH, LBU, LHU, SB, SH} = fl;
        addr      = a;
        wdata     = wd;
        #1;
        chk("stall_c0", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        st_en     = 1'($urandom);
        {LB, LH, LBU, LHU, SB, SH} = 6'($urandom);
        addr      = $urandom;
        wdata     = $urandom;

        if (mis) begin
            chk("misalign", {31'b0, misalign}, 32'd1);
            chk("req_mis", {31'b0, bus.mem_req}, 32'd0);
            chk("stall_err", {31'b0, stall}, 32'd0);
            chk("ld_hold_mis", ld_data, m_ld);
        end else begin
            acked = 0;
            for (int k = 0; k < TO; k++) begin
                chk("req", {31'b0, bus.mem_req}, 32'd1);
                chk("stall_req", {31'b0, stall}, 32'd1);
                chk("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
                chk("mem_be", {28'b0, bus.mem_be}, {28'b0, ebe});
                chk("mem_we", {31'b0, bus.mem_we}, {31'b0, st});
                if (st) chk("mem_wdata", bus.mem_wdata, ewd);
                bus.mem_ack   = (k == waits);
                bus.mem_rdata = (k == waits) ? rd : $urandom;
                tick();
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                if (k == waits) begin
                    acked = 1;
                    break;
                end
            end
            chk("req_end", {31'b0, bus.mem_req}, 32'd0);
            chk("stall_end", {31'b0, stall}, 32'd0);
            if (acked) begin
                chk("done", {31'b0, done}, 32'd1);
                chk("timeout_n", {31'b0, timeout}, 32'd0);
                if (!st) m_ld = eld;
            end else begin
                chk("timeout", {31'b0, timeout}, 32'd1);
                chk("done_n", {31'b0, done}, 32'd0);
            end
            chk("ld_data", ld_data, m_ld);
        end

        // Retiring instruction may still be shown; it must not restart.
        if (hold_valid) begin
            lsu_valid = 1'b1;
            st_en     = st;
            {LB, LH, LBU, LHU, SB, SH} = fl;
            addr      = a;
            #1;
            chk("stall_retire", {31'b0, stall}, 32'd0);
        end
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        chk("idle_req", {31'b0, bus.mem_req}, 32'd0);
        chk("pulses_off", {29'b0, done, misalign, timeout}, 32'd0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.mem_ack   = 1'($urandom);
            bus.mem_rdata = $urandom;
            tick();
            bus.mem_ack = 1'b0;
            chk("gap_done", {31'b0, done}, 32'd0);
            chk("gap_ld", ld_data, m_ld);
        end
    endtask

    initial begin
        logic        st;
        logic [5:0]  fl;
        logic [31:0] a;
        int          pick;

        rst = 1'b1;
        lsu_valid = 1'b1;
        st_en = 1'b0;
        {LB, LH, LBU, LHU, SB, SH} = 6'b0;
        addr = 32'h0;
        wdata = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_ld", ld_data, 32'h0);
        chk("rst_pulses", {29'b0, done, misalign, timeout}, 32'd0);
        lsu_valid = 1'b0;
        rst = 1'b0;
        tick();

        op(1'b1, 6'b000010, 32'h1003, 32'h000000A5, 32'h0, 0, 0);
        op(1'b0, 6'b100000, 32'h2001, 32'h0, 32'h12348056, 0, 0);
        chk("tp_lb", ld_data, 32'hFFFFFF80);
        op(1'b0, 6'b001000, 32'h2001, 32'h0, 32'h12348056, 0, 1);
        chk("tp_lbu", ld_data, 32'h00000080);
        op(1'b0, 6'b010000, 32'h2002, 32'h0, 32'hBEEF0000, 3, 0);
        chk("tp_lh", ld_data, 32'hFFFFBEEF);
        op(1'b0, 6'b000000, 32'h3002, 32'h0, 32'h0, 0, 0);
        chk("tp_lw_mis", ld_data, 32'hFFFFBEEF);
        op(1'b1, 6'b000000, 32'h3000, 32'hCAFEF00D, 32'h0, 99, 0);

        // Reset during the second REQ cycle.
        lsu_valid = 1'b1;
        st_en = 1'b0;
        {LB, LH, LBU, LHU, SB, SH} = 6'b0;
        addr = 32'h4000;
        tick();
        lsu_valid = 1'b0;
        tick();
        chk("req_pre_rst", {31'b0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_req_drop", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_stall_drop", {31'b0, stall}, 32'd0);
        chk("rst_ld_clr", ld_data, 32'h0);
        m_ld = 32'h0;
        tick();
        rst = 1'b0;
        tick();
        op(1'b0, 6'b000000, 32'h5000, 32'h0, 32'h89ABCDEF, 1, 0);

        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom);
            if ($urandom % 2 == 0) begin
                fl = 6'($urandom);
            end else if (st) begin
                pick = $urandom_range(0, 2);
                fl = (pick == 0) ? 6'b000010 : (pick == 1) ? 6'b000001 : 6'b0;
            end else begin
                pick = $urandom_range(0, 4);
                fl = (pick == 4) ? 6'b0 : 6'(6'b100000 >> pick);
            end
            a = $urandom;
            if ($urandom % 3 != 0) a[1:0] = 2'b00;
            op(st, fl, a, $urandom, $urandom, $urandom_range(0, 5), 1'($urandom));
            idle_gap($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
